// File: rtl/reg_fifo_arbiter.sv
// reg_fifo_arbiter: round-robin arbiter and sequencer in front of a shared
// 4-bit register-index FIFO that exports no full/empty status.
//   clk, reset          : clock, synchronous active-high reset (shared with the buffer)
//   req_valid/req_reg   : NUM_REQ requesters, 4-bit index each
//   req_ready           : one-hot combinational grant
//   fifo_write_en/_reg  : buffer push port
//   fifo_read_en/_reg   : buffer pop port and head
//   out_valid/out_reg   : head presented to the consumer; out_ready accepts it
//   flush/flush_done    : discard all buffered entries; one-cycle completion pulse
//   count               : registered occupancy
//   busy                : flush sequence in progress
module reg_fifo_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 32,
    localparam int unsigned PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [4*NUM_REQ-1:0] req_reg,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 fifo_write_en,
    output logic [3:0]           fifo_write_reg,
    output logic                 fifo_read_en,
    input  logic [3:0]           fifo_read_reg,
    output logic                 out_valid,
    output logic [3:0]           out_reg,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic                 flush_done,
    output logic [CW-1:0]        count,
    output logic                 busy
);

    localparam int unsigned CPW = PW + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            space;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [CPW-1:0]  cand;
    logic            pop;
    logic [3:0]      req_reg_arr [NUM_REQ];

    // Unpack the flat requester index bus.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_reg_arr[g] = req_reg[4*g +: 4];
    end

    // State, round-robin pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rr_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            count_q <= count_d;
        end
    end

    // Next-state, grant and pop logic.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        count_d        = count_q;
        gnt_any        = 1'b0;
        gnt_idx        = '0;
        cand           = '0;
        req_ready      = '0;
        fifo_write_reg = 4'h0;
        out_valid      = 1'b0;
        pop            = 1'b0;

        // A same-cycle pop does not free a slot: the buffer checks full on pre-edge pointers.
        space = (count_q < CW'(DEPTH - 1));

        // Search from rr_q upward with wrap; the first valid requester wins.
        if ((state_q == ST_RUN) && space && !flush) begin
            for (logic [CPW-1:0] k = '0; k < CPW'(NUM_REQ); k = k + CPW'(1)) begin
                cand = {1'b0, rr_q} + k;
                if (cand >= CPW'(NUM_REQ)) begin
                    cand = cand - CPW'(NUM_REQ);
                end
                if (!gnt_any && req_valid[cand[PW-1:0]]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand[PW-1:0];
                end
            end
        end

        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            fifo_write_reg     = req_reg_arr[gnt_idx];
            rr_d               = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
        end

        case (state_q)
            ST_RUN: begin
                out_valid = (count_q != '0);
                pop       = out_valid && out_ready;
                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Drain one entry per cycle; leave once empty was observed.
                pop = (count_q != '0);
                if (count_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        count_d = count_q + CW'(gnt_any) - CW'(pop);
    end

    assign fifo_write_en = gnt_any;
    assign fifo_read_en  = pop;
    assign out_reg       = fifo_read_reg;
    assign flush_done    = (state_q == ST_FLUSH) && (count_q == '0);
    assign busy          = (state_q == ST_FLUSH);
    assign count         = count_q;

endmodule
